aes_core_arbiter: RTL and testbench

Round-robin arbiter sharing one `aes_core` encryption engine among `NREQ` requesters. Accepts a key/plaintext pair from one requester at a time and drives the core's `load`. Waits for the core's `done`, or times out, and returns the cyphertext with the requester's ID over a valid/ready response channel. Sits between the host-side request ports (SPI front-ends or bus masters) and a single `aes_core` instance.

---
 rtl/aes_core_arbiter.sv | 119 +++++++++++
 tb/tb_aes_core_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one aes_core among NREQ requesters.
// Grants one key/plaintext pair at a time, waits for done or timeout, returns result over valid/ready.
module aes_core_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*128-1:0]       req_key,
   input  logic [NREQ*128-1:0]       req_plaintext,
   output logic [NREQ-1:0]           gnt,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [127:0]              rsp_cyphertext,
   output logic                      rsp_error,
   output logic                      core_load,
   output logic [127:0]              core_key,
   output logic [127:0]              core_plaintext,
   input  logic                      core_done,
   input  logic [127:0]              core_cyphertext,
   output logic                      busy
);

   localparam int IDW = $clog2(NREQ);
   // Last WAIT cycle value: the counter would reach TIMEOUT on the next increment.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RESP} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] last_gnt, sel_id, idx_b;
   logic           sel_vld;
   logic [7:0]     wait_cnt;
   logic           done_q, done_edge, timed_out;
   int             idx;

   assign done_edge = core_done && !done_q;
   assign timed_out = (wait_cnt == TO_LAST);

   // First asserted requester searching upward from last_gnt+1 with wrap.
   always_comb begin
      sel_id  = '0;
      sel_vld = 1'b0;
      idx     = 0;
      idx_b   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last_gnt) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_b = IDW'(idx);
         if (!sel_vld && req[idx_b]) begin
            sel_vld = 1'b1;
            sel_id  = idx_b;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sel_vld) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_WAIT;
         S_WAIT:  if (done_edge || timed_out) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant is qualified by reset so every output is quiet while reset is held.
   always_comb begin
      gnt = '0;
      if (state == S_IDLE && sel_vld && !reset) gnt[sel_id] = 1'b1;
      core_load = (state == S_LOAD);
      rsp_valid = (state == S_RESP);
      busy      = (state != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt       <= IDW'(NREQ - 1);
         rsp_id         <= '0;
         rsp_cyphertext <= '0;
         rsp_error      <= 1'b0;
         core_key       <= '0;
         core_plaintext <= '0;
         wait_cnt       <= '0;
         done_q         <= 1'b0;
      end else begin
         done_q <= core_done;
         case (state)
            S_IDLE: if (sel_vld) begin
               core_key       <= req_key[128*sel_id +: 128];
               core_plaintext <= req_plaintext[128*sel_id +: 128];
               rsp_id         <= sel_id;
            end
            S_LOAD: wait_cnt <= '0;
            S_WAIT: begin
               if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
               if (done_edge) begin
                  rsp_cyphertext <= core_cyphertext;
                  rsp_error      <= 1'b0;
               end else if (timed_out) begin
                  rsp_cyphertext <= '0;
                  rsp_error      <= 1'b1;
               end
            end
            S_RESP: if (rsp_ready) last_gnt <= rsp_id;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: directed scenarios plus randomized operations
// checked against a round-robin / timing model computed from the block's rules.
module tb_aes_core_arbiter;

   localparam int N  = 4;
   localparam int TO = 15;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     req = '0;
   logic [N*128-1:0] req_key, req_plaintext;
   logic [127:0]     keys [N];
   logic [127:0]     pts  [N];
   logic [N-1:0]     gnt;
   logic             rsp_valid, rsp_ready = 1'b0, rsp_error, core_load, busy;
   logic [1:0]       rsp_id;
   logic [127:0]     rsp_cyphertext, core_key, core_plaintext;
   logic             core_done = 1'b0;
   logic [127:0]     core_cyphertext = '0;

   int total = 0;
   int bad   = 0;
   int model_last;

   always #5 clk = ~clk;

   always_comb begin
      req_key       = '0;
      req_plaintext = '0;
      for (int i = 0; i < N; i++) begin
         req_key[128*i +: 128]       = keys[i];
         req_plaintext[128*i +: 128] = pts[i];
      end
   end

   aes_core_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_key(req_key), .req_plaintext(req_plaintext),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_cyphertext(rsp_cyphertext), .rsp_error(rsp_error), .core_load(core_load),
      .core_key(core_key), .core_plaintext(core_plaintext), .core_done(core_done),
      .core_cyphertext(core_cyphertext), .busy(busy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Round-robin reference: first set bit after 'last', wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic all_zero(input string tag);
      chk({tag, "_gnt"}, 128'(gnt), 0);
      chk({tag, "_valid"}, 128'(rsp_valid), 0);
      chk({tag, "_id"}, 128'(rsp_id), 0);
      chk({tag, "_ct"}, rsp_cyphertext, 0);
      chk({tag, "_err"}, 128'(rsp_error), 0);
      chk({tag, "_load"}, 128'(core_load), 0);
      chk({tag, "_key"}, core_key, 0);
      chk({tag, "_pt"}, core_plaintext, 0);
      chk({tag, "_busy"}, 128'(busy), 0);
   endtask

   // One operation: present new_req, find the grant, play the core, check every cycle to handshake.
   // done_at = cycle after grant at which core_done rises (0 = never, expect timeout).
   task automatic op(input logic [N-1:0] new_req, input bit keep, input int stale_len,
                     input int done_at, input int ready_dly, input logic [127:0] ct,
                     output int gid, output int gap);
      int id, r;
      bit found, err;
      logic done_prev;
      logic [127:0] ekey, ept, exp_ct;
      logic [N-1:0] eg;
      found = 0; gap = -1; gid = -1;
      for (int n = 0; n < 30 && !found; n++) begin
         @(posedge clk); #1;
         if (n == 0) req = new_req;
         rsp_ready = 1'b0;
         @(negedge clk);
         if (n == 0) begin
            chk("idle_busy", 128'(busy), 0);
            chk("idle_valid", 128'(rsp_valid), 0);
         end
         if (gnt != '0) begin found = 1; gap = n; end
      end
      if (!found) begin
         chk("gnt_seen", 0, 1);
         return;
      end
      id = rr_pick(req, model_last);
      gid = id;
      eg = '0;
      eg[id] = 1'b1;
      chk("gnt", 128'(gnt), 128'(eg));
      ekey = keys[id];
      ept = pts[id];
      done_prev = core_done;
      err = (done_at == 0);
      r = err ? TO + 2 : done_at + 1;
      exp_ct = err ? '0 : ct;
      for (int c = 1; c <= r + ready_dly; c++) begin
         @(posedge clk); #1;
         if (c == 1 && !keep) req[id] = 1'b0;
         if (c == 2) begin keys[id] = rand128(); pts[id] = rand128(); end
         core_done = (c < stale_len) ? done_prev : (done_at > 0 && c >= done_at);
         core_cyphertext = (c == done_at) ? ct : ~ct;
         rsp_ready = (c >= r + ready_dly);
         @(negedge clk);
         chk("core_load", 128'(core_load), 128'(c == 1));
         if (c == 1) chk("gnt_off", 128'(gnt), 0);
         chk("busy", 128'(busy), 1);
         chk("core_key", core_key, ekey);
         chk("core_pt", core_plaintext, ept);
         chk("rsp_valid", 128'(rsp_valid), 128'(c >= r));
         if (c >= r) begin
            chk("rsp_id", 128'(rsp_id), 128'(id));
            chk("rsp_error", 128'(rsp_error), 128'(err));
            chk("rsp_ct", rsp_cyphertext, exp_ct);
         end
      end
      model_last = id;
   endtask

   initial begin
      int gid, gap;
      bit found;
      for (int i = 0; i < N; i++) begin keys[i] = rand128(); pts[i] = rand128(); end
      req = '1;
      #12;
      all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      req = '0;
      model_last = N - 1;

      // Known-answer vector with a modelled core result.
      keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
      pts[0]  = 128'h00112233445566778899aabbccddeeff;
      op(4'b0001, 0, 0, 6, 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, gid, gap);
      chk("kat_id", 128'(gid), 0);

      // done still high from the previous op: only the later edge at grant+13 counts.
      op(4'b0010, 0, 5, 13, 0, rand128(), gid, gap);
      // Core never answers.
      op(4'b0100, 0, 3, 0, 0, rand128(), gid, gap);
      // Consumer stalls 5 cycles in RESP.
      op(4'b1000, 0, 3, 5, 5, rand128(), gid, gap);

      // Reset during WAIT abandons the operation.
      found = 0;
      for (int n = 0; n < 10 && !found; n++) begin
         @(posedge clk); #1;
         if (n == 0) req = 4'b0100;
         @(negedge clk);
         if (gnt != '0) found = 1;
      end
      chk("rst_gnt", 128'(gnt), 128'(4'b0100));
      @(posedge clk); #1;
      req = '0;
      core_done = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1 all_zero("async_rst");
      @(posedge clk); #1;
      reset = 1'b0;
      model_last = N - 1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         core_done = n[0];
         @(negedge clk);
         chk("post_rst_valid", 128'(rsp_valid), 0);
         chk("post_rst_busy", 128'(busy), 0);
      end
      core_done = 1'b0;

      // All requesters held high: strict rotation starting at 0, gnt right after each handshake.
      for (int k = 0; k < 5; k++) begin
         op(4'b1111, 1, 3, 4, 0, rand128(), gid, gap);
         chk("b2b_order", 128'(gid), 128'(k % N));
         if (k > 0) chk("b2b_gap", 128'(gap), 0);
      end

      for (int k = 0; k < 12; k++) begin
         int da;
         for (int i = 0; i < N; i++) begin keys[i] = rand128(); pts[i] = rand128(); end
         da = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, TO + 1));
         op(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 3, da,
            int'($urandom_range(0, 2)), rand128(), gid, gap);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
